// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
// Contents: the FSM state enum, opcode and funct values, ALU operation codes,
// and the alu_src_b / pc_src mux encodings driven onto the datapath.
// No ports (package).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPE,
    S_ALUWB,
    S_ADDI,
    S_ADDIWB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu.sv
// R-type funct decoder (purely combinational).
// Ports:
//   funct       in  6  instruction[5:0]
//   alu_code    out 3  ALU operation for a legal funct (ADD otherwise)
//   funct_legal out 1  funct is one of add/sub/and/or/slt
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_code,
  output logic       funct_legal
);

  always_comb begin
    alu_code    = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  alu_code = ALU_ADD;
      FN_SUB:  alu_code = ALU_SUB;
      FN_AND:  alu_code = ALU_AND;
      FN_OR:   alu_code = ALU_OR;
      FN_SLT:  alu_code = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a
// variable-latency memory (mem_ready handshake), drives datapath strobes and
// counts retired instructions.
// Build option: define MIPS_CTRL_ILLEGAL_TRAP_EN to make an illegal op/funct
// enter an absorbing TRAP state with illegal=1; otherwise an illegal
// instruction is dropped silently (back to FETCH) and illegal is tied 0.
// Ports:
//   clk, rst_n (async active-low)
//   op, funct, zero, mem_ready                      inputs
//   pc_write, pc_write_cond, pc_src, iord           PC / address control
//   mem_read, mem_write, ir_write                   memory / IR control
//   mem_to_reg, reg_dst, reg_write                  regfile control
//   alu_src_a, alu_src_b, alu_ctrl                  ALU control
//   instr_done, retired, illegal                    status
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic [1:0]            pc_src,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  mem_to_reg,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      retired,
  output logic                  illegal
);

  state_t     state, state_next;
  logic [2:0] rtype_code;
  logic       funct_legal;
  logic [2:0] alu_code;

  // The branch decision is made in the datapath (pc_write_cond & zero);
  // the flag is on this interface only so the port list matches the datapath.
  logic unused_zero;
  assign unused_zero = zero;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  localparam state_t BAD_NEXT = S_TRAP;
  assign illegal = (state == S_TRAP);
`else
  localparam state_t BAD_NEXT = S_FETCH;
  assign illegal = 1'b0;
`endif

  mips_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_code    (rtype_code),
    .funct_legal (funct_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PCSRC_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_code      = 3'b000;
    instr_done    = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_code  = ALU_ADD;
        pc_src    = PCSRC_ALU;
        // PC+4 and IR load happen only in the cycle the read completes
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_code  = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = funct_legal ? S_RTYPE : BAD_NEXT;
          OP_ADDI:      state_next = S_ADDI;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default:      state_next = BAD_NEXT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_code   = ALU_ADD;
        state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_next = S_FETCH;
      end
      S_RTYPE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REGB;
        alu_code   = rtype_code;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDI: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_code   = ALU_ADD;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REGB;
        alu_code      = ALU_SUB;
        pc_src        = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_IDLE;
    endcase
  end

  assign alu_ctrl = ALU_CTRL_W'(alu_code);

  // Retire counter wraps naturally modulo 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          retired <= '0;
    else if (instr_done) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl (CNT_W=4 so the wrap is reachable).
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctrl;
  logic [3:0] retired;

  mips_multicycle_ctrl #(.ALU_CTRL_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .instr_done(instr_done), .retired(retired),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] v;
    logic [3:0]  ret;
    logic        ill;
    int          id;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   step = 0;
  logic [3:0] exp_ret = 4'd0;
  logic       exp_ill = 1'b0;
  logic [5:0] cur_op = 6'd0, cur_fn = 6'd0;
  logic       cur_zero = 1'b0;

  // {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_ctrl, instr_done}
  function automatic logic [17:0] mk(input logic pw, input logic pwc,
      input logic [1:0] ps, input logic io, input logic mr, input logic mw,
      input logic irw, input logic m2r, input logic rd, input logic rw,
      input logic sa, input logic [1:0] sb, input logic [2:0] alu,
      input logic dn);
    return {pw, pwc, ps, io, mr, mw, irw, m2r, rd, rw, sa, sb, alu, dn};
  endfunction

  logic [17:0] V_Z, V_FW, V_FR, V_DEC, V_MA, V_MRD, V_MWB, V_MWW, V_MWR;
  logic [17:0] V_AWB, V_ADDI, V_IWB, V_BR, V_J;

  // Monitor: every scoreboard entry is checked on the falling edge
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      logic [17:0] act;
      e = sbq.pop_front();
      act = {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
             alu_ctrl, instr_done};
      n_chk++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL strobes step %0d: got %b expected %b", e.id, act, e.v);
      end
      n_chk++;
      if (retired !== e.ret) begin
        n_fail++;
        $display("FAIL retired step %0d: got %0d expected %0d", e.id, retired, e.ret);
      end
      n_chk++;
      if (illegal !== e.ill) begin
        n_fail++;
        $display("FAIL illegal step %0d: got %b expected %b", e.id, illegal, e.ill);
      end
    end
  end

  task automatic push(input logic [17:0] e);
    sbq.push_back('{v: e, ret: exp_ret, ill: exp_ill, id: step});
    step++;
  endtask

  task automatic cyc(input logic [17:0] e, input logic mr);
    @(posedge clk); #1;
    mem_ready = mr; op = cur_op; funct = cur_fn; zero = cur_zero;
    push(e);
    if (e[0]) exp_ret = exp_ret + 4'd1;
  endtask

  task automatic rcyc(input logic r);
    @(posedge clk); #1;
    rst_n = r; mem_ready = 1'b0;
    if (!r) begin exp_ret = 4'd0; exp_ill = 1'b0; end
    push(V_Z);
  endtask

  task automatic fetch(input int waits);
    repeat (waits) cyc(V_FW, 1'b0);
    cyc(V_FR, 1'b1);
  endtask

  task automatic do_lw(input int fw, input int rw);
    cur_op = 6'h23; fetch(fw); cyc(V_DEC, 1'b1); cyc(V_MA, 1'b1);
    repeat (rw) cyc(V_MRD, 1'b0);
    cyc(V_MRD, 1'b1); cyc(V_MWB, 1'b1);
  endtask

  task automatic do_rtype(input logic [5:0] fn, input logic [2:0] code);
    cur_op = 6'h00; cur_fn = fn; fetch(0); cyc(V_DEC, 1'b1);
    cyc(mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,code,0), 1'b1);
    cyc(V_AWB, 1'b1);
  endtask

  task automatic do_beq(input logic z);
    cur_op = 6'h04; cur_zero = z; fetch(0); cyc(V_DEC, 1'b1); cyc(V_BR, 1'b1);
  endtask

  task automatic do_j;
    cur_op = 6'h02; fetch(0); cyc(V_DEC, 1'b1); cyc(V_J, 1'b1);
  endtask

  task automatic do_illegal(input logic [5:0] o, input logic [5:0] fn);
    cur_op = o; cur_fn = fn; fetch(0); cyc(V_DEC, 1'b1);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
    repeat (3) cyc(V_Z, 1'b1);
    rcyc(1'b0); rcyc(1'b1);
`endif
  endtask

  initial begin
    V_Z    = 18'd0;
    V_FW   = mk(0,0,2'b00,0,1,0,0,0,0,0,0,2'b01,3'b010,0);
    V_FR   = mk(1,0,2'b00,0,1,0,1,0,0,0,0,2'b01,3'b010,0);
    V_DEC  = mk(0,0,2'b00,0,0,0,0,0,0,0,0,2'b11,3'b010,0);
    V_MA   = mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,3'b010,0);
    V_MRD  = mk(0,0,2'b00,1,1,0,0,0,0,0,0,2'b00,3'b000,0);
    V_MWB  = mk(0,0,2'b00,0,0,0,0,1,0,1,0,2'b00,3'b000,1);
    V_MWW  = mk(0,0,2'b00,1,0,1,0,0,0,0,0,2'b00,3'b000,0);
    V_MWR  = mk(0,0,2'b00,1,0,1,0,0,0,0,0,2'b00,3'b000,1);
    V_AWB  = mk(0,0,2'b00,0,0,0,0,0,1,1,0,2'b00,3'b000,1);
    V_ADDI = mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,3'b010,0);
    V_IWB  = mk(0,0,2'b00,0,0,0,0,0,0,1,0,2'b00,3'b000,1);
    V_BR   = mk(0,1,2'b01,0,0,0,0,0,0,0,1,2'b00,3'b110,1);
    V_J    = mk(1,0,2'b10,0,0,0,0,0,0,0,0,2'b00,3'b000,1);

    // reset, then the IDLE cycle after release
    rcyc(1'b0); rcyc(1'b0); rcyc(1'b1);

    // lw with 3 wait cycles in FETCH and 2 in MEMRD
    do_lw(3, 2);

    // R-types back to back, then addi
    do_rtype(6'b100000, 3'b010);
    do_rtype(6'b100010, 3'b110);
    do_rtype(6'b100100, 3'b000);
    do_rtype(6'b100101, 3'b001);
    do_rtype(6'b101010, 3'b111);
    cur_op = 6'h08; fetch(0); cyc(V_DEC, 1'b1); cyc(V_ADDI, 1'b1); cyc(V_IWB, 1'b1);

    // beq taken and not taken
    do_beq(1'b1);
    do_beq(1'b0);

    // sw with 2 wait cycles, then j
    cur_op = 6'h2b; fetch(0); cyc(V_DEC, 1'b1); cyc(V_MA, 1'b1);
    cyc(V_MWW, 1'b0); cyc(V_MWW, 1'b0); cyc(V_MWR, 1'b1);
    do_j();

    // reset asserted while sw waits on memory
    cur_op = 6'h2b; fetch(0); cyc(V_DEC, 1'b1); cyc(V_MA, 1'b1);
    cyc(V_MWW, 1'b0); cyc(V_MWW, 1'b0);
    rcyc(1'b0); rcyc(1'b0); rcyc(1'b1);

    // 16 jumps wrap the 4-bit counter back to 0
    repeat (16) do_j();

    // illegal opcode and illegal R-type funct
    do_illegal(6'b111111, 6'b000000);
    do_illegal(6'b000000, 6'b000111);
    do_j();

    begin : drain
      int budget;
      budget = 20;
      while (sbq.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sbq.size() > 0) begin
        n_chk++; n_fail++;
        $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
